// File: rtl/traffic_ctrl_if.sv
// Signal bundle between the intersection controller, its interval timer,
// the vehicle sensor and the lamp drivers.
interface traffic_ctrl_if;
    logic       car_req;
    logic       flash_req;
    logic       tmr_done_g;
    logic       tmr_done_y;
    logic       tmr_load;
    logic       tmr_sel;
    logic       tmr_en_h;
    logic       tmr_en_n;
    logic [2:0] hwy_light;
    logic [2:0] side_light;

    modport slave (
        input  car_req, flash_req, tmr_done_g, tmr_done_y,
        output tmr_load, tmr_sel, tmr_en_h, tmr_en_n,
        output hwy_light, side_light
    );

    modport master (
        output car_req, flash_req, tmr_done_g, tmr_done_y,
        input  tmr_load, tmr_sel, tmr_en_h, tmr_en_n,
        input  hwy_light, side_light
    );
endinterface

// File: rtl/traffic_ctrl.sv
// Highway / side-road intersection controller with all-red clearance,
// demand-driven side-road service and a flashing night/fault mode.
module traffic_ctrl #(
    parameter int unsigned ALLRED_CYC = 2,
    parameter logic [25:0] BLINK_DIV  = 26'd24_999_999
) (
    input  logic           clk,
    input  logic           rst_n,
    traffic_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        AR_H, HG, HY, AR_N, NG, NY, FLASH
    } state_e;

    localparam logic [7:0] AR_LAST = 8'(ALLRED_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  ar_cnt_q, ar_cnt_d;
    logic [25:0] blink_q, blink_d;
    logic        phase_q, phase_d;
    logic [1:0]  sync_q;
    logic        req_pend_q, req_pend_d;
    logic        g_exp_q, g_exp_d;
    logic        load_q, load_d;
    logic        sel_q, sel_d;
    logic        en_h_q, en_h_d;
    logic        en_n_q, en_n_d;
    logic [2:0]  hwy_q, hwy_d;
    logic [2:0]  side_q, side_d;
    logic        done_g, done_y, entering;

    // The timer is being (re)loaded this cycle, so any done pulse is stale.
    assign done_g = bus.tmr_done_g & ~load_q;
    assign done_y = bus.tmr_done_y & ~load_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            AR_H:  if (ar_cnt_q == AR_LAST)
                       state_d = bus.flash_req ? FLASH : HG;
            AR_N:  if (ar_cnt_q == AR_LAST)
                       state_d = bus.flash_req ? FLASH : NG;
            HG:    if ((g_exp_q | done_g) & req_pend_q)
                       state_d = HY;
            HY:    if (done_y) state_d = AR_N;
            NG:    if (done_g) state_d = NY;
            NY:    if (done_y) state_d = AR_H;
            FLASH: if (!bus.flash_req) state_d = AR_H;
            default: state_d = AR_H;
        endcase
    end

    always_comb begin
        entering = (state_d != state_q);

        ar_cnt_d = '0;
        if (!entering && (state_q == AR_H || state_q == AR_N))
            ar_cnt_d = ar_cnt_q + 8'd1;

        blink_d = '0;
        phase_d = 1'b0;
        if (state_d == FLASH) begin
            if (entering) begin
                phase_d = 1'b1;
            end else if (blink_q == BLINK_DIV) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 26'd1;
                phase_d = phase_q;
            end
        end

        // Clearing on NG entry outranks a still-present vehicle.
        req_pend_d = req_pend_q | sync_q[1];
        if (entering && state_d == NG)
            req_pend_d = 1'b0;

        g_exp_d = 1'b0;
        if (state_q == HG && state_d == HG)
            g_exp_d = g_exp_q | done_g;

        load_d = entering &&
                 (state_d == HG || state_d == HY ||
                  state_d == NG || state_d == NY);
        sel_d  = (state_d == HY || state_d == NY);
        en_h_d = (state_d == HG || state_d == HY);
        en_n_d = (state_d == NG || state_d == NY);

        hwy_d  = 3'b100;
        side_d = 3'b100;
        unique case (state_d)
            HG: hwy_d  = 3'b001;
            HY: hwy_d  = 3'b010;
            NG: side_d = 3'b001;
            NY: side_d = 3'b010;
            FLASH: begin
                hwy_d  = phase_d ? 3'b010 : 3'b000;
                side_d = phase_d ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= AR_H;
            ar_cnt_q   <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            sync_q     <= '0;
            req_pend_q <= 1'b0;
            g_exp_q    <= 1'b0;
            load_q     <= 1'b0;
            sel_q      <= 1'b0;
            en_h_q     <= 1'b0;
            en_n_q     <= 1'b0;
            hwy_q      <= 3'b100;
            side_q     <= 3'b100;
        end else begin
            state_q    <= state_d;
            ar_cnt_q   <= ar_cnt_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            sync_q     <= {sync_q[0], bus.car_req};
            req_pend_q <= req_pend_d;
            g_exp_q    <= g_exp_d;
            load_q     <= load_d;
            sel_q      <= sel_d;
            en_h_q     <= en_h_d;
            en_n_q     <= en_n_d;
            hwy_q      <= hwy_d;
            side_q     <= side_d;
        end
    end

    assign bus.tmr_load   = load_q;
    assign bus.tmr_sel    = sel_q;
    assign bus.tmr_en_h   = en_h_q;
    assign bus.tmr_en_n   = en_n_q;
    assign bus.hwy_light  = hwy_q;
    assign bus.side_light = side_q;
endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed and randomised bench for traffic_ctrl (ALLRED_CYC=2,
// BLINK_DIV=3); outputs compared as {hwy,side,load,sel,en_h,en_n}.
module tb_traffic_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_ctrl_if bus();

    traffic_ctrl #(
        .ALLRED_CYC(2),
        .BLINK_DIV (26'd3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [9:0] obs;
    assign obs = {bus.hwy_light, bus.side_light, bus.tmr_load,
                  bus.tmr_sel, bus.tmr_en_h, bus.tmr_en_n};

    localparam logic [9:0] RED    = 10'b100_100_0_0_0_0;
    localparam logic [9:0] HG_ENT = 10'b001_100_1_0_1_0;
    localparam logic [9:0] HG_RUN = 10'b001_100_0_0_1_0;
    localparam logic [9:0] HY_ENT = 10'b010_100_1_1_1_0;
    localparam logic [9:0] HY_RUN = 10'b010_100_0_1_1_0;
    localparam logic [9:0] NG_ENT = 10'b100_001_1_0_0_1;
    localparam logic [9:0] NG_RUN = 10'b100_001_0_0_0_1;
    localparam logic [9:0] NY_ENT = 10'b100_010_1_1_0_1;
    localparam logic [9:0] NY_RUN = 10'b100_010_0_1_0_1;
    localparam logic [9:0] FL_ON  = 10'b010_100_0_0_0_0;
    localparam logic [9:0] FL_OFF = 10'b000_000_0_0_0_0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_g;
        bus.tmr_done_g = 1'b1;
        tick();
        bus.tmr_done_g = 1'b0;
    endtask

    task automatic pulse_y;
        bus.tmr_done_y = 1'b1;
        tick();
        bus.tmr_done_y = 1'b0;
    endtask

    task automatic wait_hy(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 8 && !found; i++) begin
            tick();
            if (bus.hwy_light == 3'b010) begin
                found = 1'b1;
                n = i;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.car_req = 1'b0;
        bus.flash_req = 1'b0;
        bus.tmr_done_g = 1'b0;
        bus.tmr_done_y = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL reset_out: got %b want %b", obs, RED);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL allred_1: got %b want %b", obs, RED);
        end
        tick();
        checks++;
        if (obs !== HG_ENT) begin
            errors++;
            $display("FAIL hg_entry: got %b want %b", obs, HG_ENT);
        end
        tick();
        checks++;
        if (obs !== HG_RUN) begin
            errors++;
            $display("FAIL hg_run: got %b want %b", obs, HG_RUN);
        end
    endtask

    task automatic test_hg_hold;
        pulse_g();
        tick();
        tick();
        tick();
        checks++;
        if (obs !== HG_RUN) begin
            errors++;
            $display("FAIL hg_hold: got %b want %b", obs, HG_RUN);
        end
    endtask

    task automatic test_car;
        int n;
        bus.car_req = 1'b1;
        wait_hy(n);
        checks++;
        if (n < 3 || n > 4) begin
            errors++;
            $display("FAIL hy_latency: got %0d want 3..4", n);
        end
        checks++;
        if (obs !== HY_ENT) begin
            errors++;
            $display("FAIL hy_entry: got %b want %b", obs, HY_ENT);
        end
        bus.car_req = 1'b0;
        tick();
        checks++;
        if (obs !== HY_RUN) begin
            errors++;
            $display("FAIL hy_run: got %b want %b", obs, HY_RUN);
        end
        pulse_y();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL ar_n_1: got %b want %b", obs, RED);
        end
        tick();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL ar_n_2: got %b want %b", obs, RED);
        end
        tick();
        checks++;
        if (obs !== NG_ENT) begin
            errors++;
            $display("FAIL ng_entry: got %b want %b", obs, NG_ENT);
        end
    endtask

    task automatic test_ng_ignore;
        bus.tmr_done_g = 1'b1;
        bus.tmr_done_y = 1'b1;
        tick();
        bus.tmr_done_g = 1'b0;
        bus.tmr_done_y = 1'b0;
        checks++;
        if (obs !== NG_RUN) begin
            errors++;
            $display("FAIL ng_ignore_load: got %b want %b", obs, NG_RUN);
        end
        pulse_y();
        checks++;
        if (obs !== NG_RUN) begin
            errors++;
            $display("FAIL ng_ignore_y: got %b want %b", obs, NG_RUN);
        end
        pulse_g();
        checks++;
        if (obs !== NY_ENT) begin
            errors++;
            $display("FAIL ny_entry: got %b want %b", obs, NY_ENT);
        end
        tick();
        checks++;
        if (obs !== NY_RUN) begin
            errors++;
            $display("FAIL ny_run: got %b want %b", obs, NY_RUN);
        end
        pulse_y();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL ar_h_after_ny: got %b want %b", obs, RED);
        end
        tick();
        tick();
        checks++;
        if (obs !== HG_ENT) begin
            errors++;
            $display("FAIL hg_reentry: got %b want %b", obs, HG_ENT);
        end
        tick();
        pulse_g();
        tick();
        tick();
        checks++;
        if (obs !== HG_RUN) begin
            errors++;
            $display("FAIL req_pend_cleared: got %b want %b", obs, HG_RUN);
        end
    endtask

    task automatic test_flash;
        int n;
        logic [9:0] exp_v;
        bus.car_req = 1'b1;
        wait_hy(n);
        checks++;
        if (obs !== HY_ENT) begin
            errors++;
            $display("FAIL fl_hy_entry: got %b want %b", obs, HY_ENT);
        end
        bus.car_req = 1'b0;
        tick();
        pulse_y();
        tick();
        tick();
        checks++;
        if (obs !== NG_ENT) begin
            errors++;
            $display("FAIL fl_ng_entry: got %b want %b", obs, NG_ENT);
        end
        tick();
        pulse_g();
        checks++;
        if (obs !== NY_ENT) begin
            errors++;
            $display("FAIL fl_ny_entry: got %b want %b", obs, NY_ENT);
        end
        bus.flash_req = 1'b1;
        tick();
        pulse_y();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL fl_ar_h: got %b want %b", obs, RED);
        end
        tick();
        tick();
        for (int k = 0; k < 12; k++) begin
            if (k != 0) tick();
            exp_v = (((k / 4) % 2) == 0) ? FL_ON : FL_OFF;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL flash_k%0d: got %b want %b", k, obs, exp_v);
            end
        end
        bus.flash_req = 1'b0;
        tick();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL flash_exit: got %b want %b", obs, RED);
        end
        tick();
        tick();
        checks++;
        if (obs !== HG_ENT) begin
            errors++;
            $display("FAIL flash_hg: got %b want %b", obs, HG_ENT);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        tick();
        pulse_g();
        bus.car_req = 1'b1;
        wait_hy(n);
        checks++;
        if (obs !== HY_ENT) begin
            errors++;
            $display("FAIL mid_hy_entry: got %b want %b", obs, HY_ENT);
        end
        bus.car_req = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want %b", obs, RED);
        end
        tick();
        tick();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL mid_reset_hold: got %b want %b", obs, RED);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== RED) begin
            errors++;
            $display("FAIL mid_release: got %b want %b", obs, RED);
        end
        tick();
        checks++;
        if (obs !== HG_ENT) begin
            errors++;
            $display("FAIL mid_hg: got %b want %b", obs, HG_ENT);
        end
    endtask

    task automatic test_random;
        logic prev_load;
        logic hwy_go, side_go;
        prev_load = bus.tmr_load;
        for (int i = 0; i < 400; i++) begin
            bus.car_req    = ($urandom_range(0, 3) == 0);
            bus.tmr_done_g = ($urandom_range(0, 3) == 0);
            bus.tmr_done_y = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0)
                bus.flash_req = ~bus.flash_req;
            tick();
            hwy_go  = (bus.hwy_light != 3'b100) && (bus.hwy_light != 3'b000);
            side_go = (bus.side_light != 3'b100) && (bus.side_light != 3'b000);
            checks++;
            if (hwy_go && side_go) begin
                errors++;
                $display("FAIL conflict_c%0d: got %b/%b want one red",
                         i, bus.hwy_light, bus.side_light);
            end
            checks++;
            if (bus.tmr_load && prev_load) begin
                errors++;
                $display("FAIL load_twice_c%0d: got 1,1 want not both", i);
            end
            prev_load = bus.tmr_load;
        end
        bus.car_req = 1'b0;
        bus.flash_req = 1'b0;
        bus.tmr_done_g = 1'b0;
        bus.tmr_done_y = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hg_hold();
        test_car();
        test_ng_ignore();
        test_flash();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
